// File: rtl/combo_entry.sv
// combo_entry: multi-digit combination entry, code check and attempt limiting.
// Optional lockout state and timer are built only when COMBO_ENTRY_LOCKOUT_EN
// is defined; otherwise a mismatch always returns to entry and locked_out is 0.
module combo_entry #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned DIGIT_MAX      = 9,
  parameter int unsigned MAX_ATTEMPTS   = 3,
  parameter int unsigned LOCKOUT_CYCLES = 100000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    up,
  input  logic                    down,
  input  logic                    left,
  input  logic                    right,
  input  logic                    enter,
  input  logic [4*NUM_DIGITS-1:0] code,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [2:0]              cursor,
  output logic                    unlocked,
  output logic                    locked_out,
  output logic [3:0]              fail_count
);

  localparam int unsigned CUR_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_CHECK   = 2'd1,
    ST_OPEN    = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  state_t                          state_q, state_d;
  logic [NUM_DIGITS-1:0][3:0]      digits_q, digits_d;
  logic [2:0]                      cursor_q, cursor_d;
  logic [3:0]                      fail_q, fail_d;
  logic                            unlocked_q, unlocked_d;
  logic [CUR_W-1:0]                cur_idx;
  logic [3:0]                      cur_digit;
  logic [3:0]                      fail_inc;
  logic                            code_match;

  assign cur_idx   = cursor_q[CUR_W-1:0];
  assign cur_digit = digits_q[cur_idx];
  assign fail_inc  = (fail_q == 4'hf) ? 4'hf : fail_q + 4'd1;
  // Entered digits never exceed DIGIT_MAX, so an out-of-range code digit cannot match.
  assign code_match = (digits_q == code);

`ifdef COMBO_ENTRY_LOCKOUT_EN
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             locked_out_q, locked_out_d;
`else
  logic             cfg_unused;
  assign cfg_unused = ^{CNT_W'(MAX_ATTEMPTS), CNT_W'(LOCKOUT_CYCLES)};
`endif

  // Next-state, edit/move and check logic.
  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    cursor_d = cursor_q;
    fail_d   = fail_q;
`ifdef COMBO_ENTRY_LOCKOUT_EN
    lock_cnt_d = lock_cnt_q;
`endif
    case (state_q)
      ST_ENTRY: begin
        if (enter) begin
          state_d = ST_CHECK;
        end else begin
          if (up && !down) begin
            digits_d[cur_idx] = (cur_digit == 4'(DIGIT_MAX)) ? 4'd0 : cur_digit + 4'd1;
          end else if (down && !up) begin
            digits_d[cur_idx] = (cur_digit == 4'd0) ? 4'(DIGIT_MAX) : cur_digit - 4'd1;
          end
          if (left && !right) begin
            cursor_d = (cursor_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : cursor_q + 3'd1;
          end else if (right && !left) begin
            cursor_d = (cursor_q == 3'd0) ? 3'(NUM_DIGITS - 1) : cursor_q - 3'd1;
          end
        end
      end
      ST_CHECK: begin
        if (code_match) begin
          state_d = ST_OPEN;
          fail_d  = 4'd0;
        end else begin
          fail_d   = fail_inc;
          digits_d = '0;
          cursor_d = 3'd0;
          state_d  = ST_ENTRY;
`ifdef COMBO_ENTRY_LOCKOUT_EN
          if (fail_inc >= 4'(MAX_ATTEMPTS)) begin
            state_d    = ST_LOCKOUT;
            lock_cnt_d = CNT_W'(LOCKOUT_CYCLES - 1);
          end
`endif
        end
      end
      ST_OPEN: begin
        if (enter) begin
          state_d  = ST_ENTRY;
          digits_d = '0;
          cursor_d = 3'd0;
        end
      end
`ifdef COMBO_ENTRY_LOCKOUT_EN
      ST_LOCKOUT: begin
        if (lock_cnt_q == '0) begin
          state_d = ST_ENTRY;
          fail_d  = 4'd0;
        end else begin
          lock_cnt_d = lock_cnt_q - CNT_W'(1);
        end
      end
`endif
      default: begin
        state_d = ST_ENTRY;
      end
    endcase
  end

  // Status flags registered from the next state so they align with it.
  always_comb begin
    unlocked_d = (state_d == ST_OPEN);
`ifdef COMBO_ENTRY_LOCKOUT_EN
    locked_out_d = (state_d == ST_LOCKOUT);
`endif
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ENTRY;
      digits_q   <= '0;
      cursor_q   <= 3'd0;
      fail_q     <= 4'd0;
      unlocked_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      digits_q   <= digits_d;
      cursor_q   <= cursor_d;
      fail_q     <= fail_d;
      unlocked_q <= unlocked_d;
    end
  end

`ifdef COMBO_ENTRY_LOCKOUT_EN
  // Lockout timer and flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_cnt_q   <= '0;
      locked_out_q <= 1'b0;
    end else begin
      lock_cnt_q   <= lock_cnt_d;
      locked_out_q <= locked_out_d;
    end
  end
  assign locked_out = locked_out_q;
`else
  assign locked_out = 1'b0;
`endif

  assign digits     = digits_q;
  assign cursor     = cursor_q;
  assign unlocked   = unlocked_q;
  assign fail_count = fail_q;

endmodule
